// File: rtl/rom_arbiter_if.sv
// Client- and ROM-side signal bundle for rom_arbiter.
// The arbiter connects through the slave modport; the clients and the ROM connect through master.
interface rom_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  // Handshake: each req is a level request, with its add held stable while req is high.
  // gnt is a one-cycle pulse that marks acceptance, and the client drops req in that cycle
  // to make exactly one read. rvalid is a one-cycle strobe that cannot be stalled. rdata
  // holds its value between strobes.
  logic          req0;
  logic          req1;
  logic [AW-1:0] add0;
  logic [AW-1:0] add1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          rom_rd;
  logic [AW-1:0] rom_add;
  logic [DW-1:0] rom_data;
  logic          busy;
  logic [7:0]    rd_count;

  modport master (
    output req0, req1, add0, add1, rom_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_rd, rom_add, busy, rd_count
  );

  modport slave (
    input  req0, req1, add0, add1, rom_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_rd, rom_add, busy, rd_count
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-client read arbiter and sequencer for the 8x8 synchronous ROM (one read per 3 cycles).
// The default build uses round-robin arbitration. Defining ROM_ARB_FIXED_PRI_EN makes client 0 win every contention.
module rom_arbiter #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   grant;
  logic   capture;
  logic   win;
  logic   owner;

`ifdef ROM_ARB_FIXED_PRI_EN
  assign win = ~bus.req0;
`else
  logic last;

  // On contention, the client that did not win last time gets the grant.
  assign win = (bus.req0 && bus.req1) ? ~last : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last <= 1'b1;
    else if (grant) last <= win;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req0 || bus.req1) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:    grant   = bus.req0 || bus.req1;
      CAPTURE: capture = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

  // The grant and response strobes are set only by their trigger, so every other edge clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.rom_rd   <= 1'b0;
      bus.rom_add  <= '0;
      owner        <= 1'b0;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.rdata0   <= '0;
      bus.rdata1   <= '0;
      bus.rd_count <= '0;
    end else begin
      bus.gnt0    <= grant && !win;
      bus.gnt1    <= grant && win;
      bus.rom_rd  <= grant;
      bus.rvalid0 <= capture && !owner;
      bus.rvalid1 <= capture && owner;
      if (grant) begin
        owner       <= win;
        bus.rom_add <= win ? bus.add1 : bus.add0;
      end
      if (capture) begin
        if (owner) bus.rdata1 <= bus.rom_data;
        else       bus.rdata0 <= bus.rom_data;
        bus.rd_count <= bus.rd_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

- Two-requester read arbiter and sequencer for the team's 8×8 synchronous ROM.
- Accepts level read requests from two clients and grants one per transaction: round-robin by default, fixed priority as a build option.
- Drives the ROM's `rd`/`add` inputs, captures `data_out` once the ROM's one-cycle registered read completes, and returns the byte to the granted client with a one-cycle valid strobe.
- Sits between the ROM instance and its consumers; it is the only driver of the ROM's control inputs.

## Interface
- `AW`, default 3: ROM address width.
- `DW`, default 8: ROM data width.
- `clk` input, 1: single clock, all logic on rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `req0` / `req1` input, 1: read request from client 0 / client 1 (level).
- `add0` / `add1` input, AW: read address, stable while the matching `req` is high.
- `gnt0` / `gnt1` output, 1: one-cycle grant pulse.
- `rvalid0` / `rvalid1` output, 1: one-cycle response strobe.
- `rdata0` / `rdata1` output, DW: response data; holds its last value between responses.
- `rom_rd` output, 1: to ROM `rd`.
- `rom_add` output, AW: to ROM `add`.
- `rom_data` input, DW: from ROM `data_out`.
- `busy` output, 1: high whenever state ≠ IDLE.
- `rd_count` output, 8: completed-read counter, wraps 255→0.

## Operation
- FSM: IDLE → ISSUE → CAPTURE → IDLE. One read per 3 cycles.
- IDLE, with any `req` sampled high at edge E0:
  - select a winner; register `gnt_w`=1, `rom_rd`=1, `rom_add`=`add_w`; latch winner ID; go to ISSUE.
- IDLE, no request: all strobes 0; stay in IDLE.
- ISSUE (edge E1):
  - the ROM samples `rd`/`add`; `gnt_w`←0, `rom_rd`←0; `rom_add` holds; go to CAPTURE.
- CAPTURE (edge E2):
  - `rdata_w`←`rom_data`, `rvalid_w`←1, `rd_count`←`rd_count`+1 (mod 256); go to IDLE.
  - `rvalid_w` drops at the next edge.
- Round-robin: register `last` records the previous winner.
  - If both requests are high, the client ≠ `last` wins.
  - If only one request is high, that client wins regardless of `last`.
  - `last` updates at grant.
- Requests are sampled only in IDLE. `req` edges during ISSUE/CAPTURE are ignored.
- A `req` still high at the next IDLE edge counts as a new request. To make a single read, the client deasserts `req` on the cycle it sees `gnt`.
- The non-winning client's `rdata`/`rvalid` are untouched.
- Reset values: `gnt0`/`gnt1`/`rvalid0`/`rvalid1`/`rom_rd`/`busy` = 0; `rdata0`/`rdata1`/`rom_add`/`rd_count` = 0; state = IDLE; `last` = 1 (client 0 wins the first contention).
- Reset asserted mid-transaction: all registers return to reset values immediately.
  - The pending response is dropped: no `rvalid`, no count increment.
  - A ROM `data_out` update already in flight is ignored.

## Timing
- All outputs are registered; there is no combinational path from `req`/`add` to any output.
- Given `req` sampled at E0:
  - `gnt` is high for cycle E0–E1.
  - `rom_rd` is high for cycle E0–E1.
  - `rom_data` is valid after E1.
  - `rvalid` plus `rdata` are high/valid for cycle E2–E3.
- Latency: 3 edges from request sample to response strobe.
- Back-to-back: the next grant is at the earliest edge E3. Maximum throughput is 1 read per 3 cycles.
- `busy` is high from E0 to E2, low after E2 unless a new grant occurs at E3.

## Configuration
- `ROM_ARB_FIXED_PRI_EN`, defined: fixed priority. Client 0 always wins contention; `last` is not implemented.
- Not defined: round-robin as described above.
- Both builds are otherwise identical in latency, ports and reset values.

## Test plan
The bench uses the team ROM image: addr0=108, addr1=10, addr2=106, addr3=56, addr4=45, addr5=130, addr6=201, addr7=217.
- Reset check: hold `rst_n`=0 for 3 cycles, then release with no requests → all outputs 0, `busy`=0.
- Single read: `req0`=1, `add0`=3, dropped on `gnt0` → `gnt0` pulse at E0, `rom_rd`=1 / `rom_add`=3 for one cycle, `rvalid0`=1 with `rdata0`=56 after E2, `rd_count`=1, `rvalid1` stays 0.
- Contention, round-robin: `req0`/`req1` held high, `add0`=5, `add1`=7, for 4 transactions → grant order 0,1,0,1; responses 130,217,130,217; `rd_count`=4.
  - Under `ROM_ARB_FIXED_PRI_EN`: all four go to client 0 (130), and client 1 gets no grant.
- Mid-transaction request: `req1` asserted during ISSUE of a client-0 read → no grant until the IDLE edge E3; `gnt1` is high for cycle E3–E4.
- Reset mid-operation: pull `rst_n` low during CAPTURE → no `rvalid`, `rd_count` unchanged at 0, state IDLE; after release a fresh read of addr 6 returns 201.
- Counter wrap: 256 reads of addr 1 → every `rdata0`=10; `rd_count` wraps to 0 on the 256th completion.
